// File: rtl/cpu_e_reg.sv
// Decode-to-execute pipeline register of the MCS8 core: captures forwarded
// operands and write selects, inserts one-cycle load-use bubbles and counts them.
module cpu_e_reg (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       HOLD_I,
  input  logic       FLUSH_I,
  input  logic       D_VALID_I,
  input  logic [3:0] D_ICODE_I,
  input  logic [7:0] D_VAL_A_I,
  input  logic [7:0] D_VAL_B_I,
  input  logic [2:0] D_SRC_A_I,
  input  logic [2:0] D_SRC_B_I,
  input  logic       D_SRC_A_CS_I,
  input  logic       D_SRC_B_CS_I,
  input  logic [2:0] D_DST_I,
  input  logic       D_DSTR_CS_I,
  input  logic       D_DSTR_CS_C_I,
  input  logic       D_DSTR_CS_S_I,
  input  logic       D_DSTR_CS_E_I,
  input  logic       D_DSTR_CS_M_I,
  output logic       E_VALID_O,
  output logic [3:0] E_ICODE_O,
  output logic [7:0] E_VAL_A_O,
  output logic [7:0] E_VAL_B_O,
  output logic [2:0] E_DST_O,
  output logic       E_DSTR_CS_O,
  output logic       E_DSTR_CS_C_O,
  output logic       E_DSTR_CS_S_O,
  output logic       E_DSTR_CS_E_O,
  output logic       E_DSTR_CS_M_O,
  output logic       STALL_O,
  output logic [7:0] BUBBLE_CNT_O
);

  logic e_is_load;
  logic src_a_match;
  logic src_b_match;
  logic hazard;
  logic d_cs_keep;

  // The held instruction is a load whose result a consumer in decode needs now.
  assign e_is_load   = E_VALID_O & E_DSTR_CS_O & E_DSTR_CS_M_O;
  assign src_a_match = D_SRC_A_CS_I & (D_SRC_A_I == E_DST_O);
  assign src_b_match = D_SRC_B_CS_I & (D_SRC_B_I == E_DST_O);
  assign hazard      = e_is_load & D_VALID_I & (src_a_match | src_b_match);
  assign STALL_O     = hazard & ~FLUSH_I;
  assign d_cs_keep   = D_VALID_I;

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      E_VALID_O     <= 1'b0;
      E_ICODE_O     <= 4'd0;
      E_VAL_A_O     <= 8'd0;
      E_VAL_B_O     <= 8'd0;
      E_DST_O       <= 3'd0;
      E_DSTR_CS_O   <= 1'b0;
      E_DSTR_CS_C_O <= 1'b0;
      E_DSTR_CS_S_O <= 1'b0;
      E_DSTR_CS_E_O <= 1'b0;
      E_DSTR_CS_M_O <= 1'b0;
      BUBBLE_CNT_O  <= 8'd0;
    end else if (!HOLD_I) begin
      if (FLUSH_I || hazard) begin
        // Bubble: selects cleared so downstream forwarding never matches it.
        E_VALID_O     <= 1'b0;
        E_ICODE_O     <= 4'd0;
        E_VAL_A_O     <= 8'd0;
        E_VAL_B_O     <= 8'd0;
        E_DST_O       <= 3'd0;
        E_DSTR_CS_O   <= 1'b0;
        E_DSTR_CS_C_O <= 1'b0;
        E_DSTR_CS_S_O <= 1'b0;
        E_DSTR_CS_E_O <= 1'b0;
        E_DSTR_CS_M_O <= 1'b0;
        if (!FLUSH_I && BUBBLE_CNT_O != 8'hFF) begin
          BUBBLE_CNT_O <= BUBBLE_CNT_O + 8'd1;
        end
      end else begin
        E_VALID_O     <= D_VALID_I;
        E_ICODE_O     <= D_ICODE_I;
        E_VAL_A_O     <= D_VAL_A_I;
        E_VAL_B_O     <= D_VAL_B_I;
        E_DST_O       <= D_DST_I;
        E_DSTR_CS_O   <= D_DSTR_CS_I   & d_cs_keep;
        E_DSTR_CS_C_O <= D_DSTR_CS_C_I & d_cs_keep;
        E_DSTR_CS_S_O <= D_DSTR_CS_S_I & d_cs_keep;
        E_DSTR_CS_E_O <= D_DSTR_CS_E_I & d_cs_keep;
        E_DSTR_CS_M_O <= D_DSTR_CS_M_I & d_cs_keep;
      end
    end
  end

endmodule

// File: tb/tb_cpu_e_reg.sv
// Self-checking bench for cpu_e_reg: directed scenarios plus random traffic,
// all compared against a behavioural model of the execute-stage register.
module tb_cpu_e_reg;

  logic       clk = 1'b0;
  logic       rst, hold, flush;
  logic       d_valid;
  logic [3:0] d_icode;
  logic [7:0] d_val_a, d_val_b;
  logic [2:0] d_src_a, d_src_b;
  logic       d_src_a_cs, d_src_b_cs;
  logic [2:0] d_dst;
  logic       d_cs, d_cs_c, d_cs_s, d_cs_e, d_cs_m;

  logic       e_valid;
  logic [3:0] e_icode;
  logic [7:0] e_val_a, e_val_b;
  logic [2:0] e_dst;
  logic       e_cs, e_cs_c, e_cs_s, e_cs_e, e_cs_m;
  logic       stall;
  logic [7:0] bubble_cnt;

  int checks = 0;
  int passes = 0;

  // Model state: the instruction sitting in execute and the bubble tally.
  typedef struct {
    bit       valid;
    bit [3:0] icode;
    bit [7:0] a, b;
    bit [2:0] dst;
    bit       cs, c, s, e, m;
  } instr_t;
  instr_t m_e;
  int     m_cnt;

  always #5 clk = ~clk;

  cpu_e_reg dut (
    .CLK_I(clk), .RST_I(rst), .HOLD_I(hold), .FLUSH_I(flush),
    .D_VALID_I(d_valid), .D_ICODE_I(d_icode),
    .D_VAL_A_I(d_val_a), .D_VAL_B_I(d_val_b),
    .D_SRC_A_I(d_src_a), .D_SRC_B_I(d_src_b),
    .D_SRC_A_CS_I(d_src_a_cs), .D_SRC_B_CS_I(d_src_b_cs),
    .D_DST_I(d_dst), .D_DSTR_CS_I(d_cs),
    .D_DSTR_CS_C_I(d_cs_c), .D_DSTR_CS_S_I(d_cs_s),
    .D_DSTR_CS_E_I(d_cs_e), .D_DSTR_CS_M_I(d_cs_m),
    .E_VALID_O(e_valid), .E_ICODE_O(e_icode),
    .E_VAL_A_O(e_val_a), .E_VAL_B_O(e_val_b), .E_DST_O(e_dst),
    .E_DSTR_CS_O(e_cs), .E_DSTR_CS_C_O(e_cs_c), .E_DSTR_CS_S_O(e_cs_s),
    .E_DSTR_CS_E_O(e_cs_e), .E_DSTR_CS_M_O(e_cs_m),
    .STALL_O(stall), .BUBBLE_CNT_O(bubble_cnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
  endtask

  // Does the consumer in decode need a register that the load in execute has yet to produce?
  function automatic bit modelHazard();
    bit needs_a, needs_b;
    if (!(m_e.valid && m_e.cs && m_e.m && d_valid)) return 1'b0;
    needs_a = d_src_a_cs && (d_src_a == m_e.dst);
    needs_b = d_src_b_cs && (d_src_b == m_e.dst);
    return needs_a || needs_b;
  endfunction

  function automatic logic [31:0] packModel();
    return {3'b0, m_e.valid, m_e.icode, m_e.a, m_e.b, m_e.dst, m_e.cs, m_e.c, m_e.s, m_e.e, m_e.m};
  endfunction

  function automatic logic [31:0] packDut();
    return {3'b0, e_valid, e_icode, e_val_a, e_val_b, e_dst, e_cs, e_cs_c, e_cs_s, e_cs_e, e_cs_m};
  endfunction

  // One clock: check the combinational stall, clock the model alongside the DUT, check the registers.
  task automatic applyStimulus();
    bit hz;
    instr_t bubble;
    #1;
    hz = modelHazard();
    checkOutput("stall", {31'b0, stall}, {31'b0, hz && !flush});
    @(posedge clk);
    bubble = '{default: 0};
    if (rst) begin
      m_e   = bubble;
      m_cnt = 0;
    end else if (!hold) begin
      if (flush || hz) begin
        m_e = bubble;
        if (!flush) m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
      end else begin
        m_e.valid = d_valid;
        m_e.icode = d_icode;
        m_e.a     = d_val_a;
        m_e.b     = d_val_b;
        m_e.dst   = d_dst;
        m_e.cs    = d_valid && d_cs;
        m_e.c     = d_valid && d_cs_c;
        m_e.s     = d_valid && d_cs_s;
        m_e.e     = d_valid && d_cs_e;
        m_e.m     = d_valid && d_cs_m;
      end
    end
    #1;
    checkOutput("e_regs", packDut(), packModel());
    checkOutput("bubble_cnt", {24'b0, bubble_cnt}, m_cnt);
  endtask

  task automatic idle();
    {rst, hold, flush} = 3'b0;
    d_valid = 0; d_icode = 0; d_val_a = 0; d_val_b = 0;
    d_src_a = 0; d_src_b = 0; d_src_a_cs = 0; d_src_b_cs = 0;
    d_dst = 0; {d_cs, d_cs_c, d_cs_s, d_cs_e, d_cs_m} = 5'b0;
  endtask

  task automatic presentLoad(input logic [2:0] dst);
    idle();
    d_valid = 1; d_icode = 4'h9; d_val_a = 8'h40; d_dst = dst;
    d_cs = 1; d_cs_m = 1;
  endtask

  task automatic presentConsumer(input logic [2:0] src, input logic src_cs);
    idle();
    d_valid = 1; d_icode = 4'h2; d_val_a = 8'h11; d_val_b = 8'h22;
    d_src_a = src; d_src_a_cs = src_cs; d_dst = 3'd4; d_cs = 1; d_cs_e = 1;
  endtask

  initial begin
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    m_e   = '{default: 0};
    m_cnt = 0;

    // Reset after a valid instruction clears everything.
    idle();
    d_valid = 1; d_val_a = 8'h5A; d_val_b = 8'hC3; d_dst = 3; d_cs = 1; d_cs_e = 1;
    applyStimulus();
    rst = 1;
    applyStimulus();
    idle();
    checkOutput("reset_regs", packDut(), 32'd0);
    applyStimulus();

    // Pass-through of an ALU instruction.
    idle();
    d_valid = 1; d_icode = 4'h7; d_val_a = 8'h12; d_val_b = 8'h34; d_dst = 5; d_cs = 1; d_cs_e = 1;
    applyStimulus();
    checkOutput("pass_a", {24'b0, e_val_a}, 32'h12);

    // Load-use on operand A: one bubble, then the consumer goes through.
    presentLoad(3'd2);
    applyStimulus();
    presentConsumer(3'd2, 1'b1);
    #1;
    checkOutput("lu_stall", {31'b0, stall}, 32'd1);
    applyStimulus();
    checkOutput("lu_cnt", {24'b0, bubble_cnt}, 32'd1);
    applyStimulus();
    checkOutput("lu_loaded", {31'b0, e_valid}, 32'd1);

    // No hazard when the source is unused, or when the producer is not a load.
    presentLoad(3'd2);
    applyStimulus();
    presentConsumer(3'd2, 1'b0);
    applyStimulus();
    idle();
    d_valid = 1; d_dst = 2; d_cs = 1; d_cs_e = 1;
    applyStimulus();
    presentConsumer(3'd2, 1'b1);
    applyStimulus();
    checkOutput("nofalse_cnt", {24'b0, bubble_cnt}, 32'd1);

    // Hazard on R0 under hold for three cycles, then released with a flush.
    presentLoad(3'd0);
    applyStimulus();
    presentConsumer(3'd0, 1'b1);
    hold = 1;
    repeat (3) applyStimulus();
    hold = 0; flush = 1;
    applyStimulus();
    checkOutput("flush_cnt", {24'b0, bubble_cnt}, 32'd1);
    idle();
    applyStimulus();

    // A self-dependent load re-presented forever alternates load/bubble: 256+ bubbles.
    idle();
    d_valid = 1; d_icode = 4'h9; d_src_a = 3'd6; d_src_a_cs = 1; d_dst = 3'd6; d_cs = 1; d_cs_m = 1;
    repeat (520) applyStimulus();
    checkOutput("sat_cnt", {24'b0, bubble_cnt}, 32'd255);

    // Random traffic with small register indices so hazards are frequent.
    for (int i = 0; i < 600; i++) begin
      int sel;
      rst        = ($urandom_range(0, 59) == 0);
      hold       = ($urandom_range(0, 7) == 0);
      flush      = ($urandom_range(0, 9) == 0);
      d_valid    = ($urandom_range(0, 3) != 0);
      d_icode    = 4'($urandom);
      d_val_a    = 8'($urandom);
      d_val_b    = 8'($urandom);
      d_src_a    = 3'($urandom_range(0, 3));
      d_src_b    = 3'($urandom_range(0, 3));
      d_src_a_cs = 1'($urandom);
      d_src_b_cs = 1'($urandom);
      d_dst      = 3'($urandom_range(0, 3));
      d_cs       = ($urandom_range(0, 3) != 0);
      sel        = $urandom_range(0, 5);
      d_cs_c     = (sel == 0);
      d_cs_s     = (sel == 1);
      d_cs_e     = (sel == 2);
      d_cs_m     = (sel >= 3);
      applyStimulus();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/cpu_e_reg.md
# cpu_e_reg

Decode-to-execute pipeline register of the MCS8 pipelined core. Sits directly downstream of the operand-forwarding logic: it captures the two forwarded 8-bit operands together with the instruction's destination and write-source selects, and presents them to the execute stage one cycle later. It also:
- detects load-use hazards against the instruction it currently holds;
- inserts a bubble and stalls the fetch/decode stages for exactly one cycle on such a hazard;
- counts inserted bubbles for performance monitoring.

## Interface
- No parameters; all widths fixed (8-bit data, 3-bit register index, 4-bit opcode).
- CLK_I  in  1  core clock, all state updates on rising edge.
- RST_I  in  1  reset, synchronous, active-high.
- HOLD_I  in  1  global freeze (memory wait); all state held.
- FLUSH_I  in  1  branch mispredict; squash incoming instruction.
- D_VALID_I  in  1  decode-stage instruction valid.
- D_ICODE_I  in  4  decode-stage opcode.
- D_VAL_A_I, D_VAL_B_I  in  8  forwarded operands A/B.
- D_SRC_A_I, D_SRC_B_I  in  3  source register indices.
- D_SRC_A_CS_I, D_SRC_B_CS_I  in  1  source actually read.
- D_DST_I  in  3  destination register index.
- D_DSTR_CS_I  in  1  instruction writes a register.
- D_DSTR_CS_C_I, D_DSTR_CS_S_I, D_DSTR_CS_E_I, D_DSTR_CS_M_I  in  1  one-hot write-source select: constant, shift, ALU, memory.
- E_VALID_O  out  1  execute-stage valid.
- E_ICODE_O  out  4  registered opcode.
- E_VAL_A_O, E_VAL_B_O  out  8  registered operands.
- E_DST_O  out  3  registered destination.
- E_DSTR_CS_O, E_DSTR_CS_C_O, E_DSTR_CS_S_O, E_DSTR_CS_E_O, E_DSTR_CS_M_O  out  1  registered selects.
- STALL_O  out  1  combinational; fetch/decode must hold this cycle.
- BUBBLE_CNT_O  out  8  saturating count of inserted load-use bubbles.

## Operation
- Load-use hazard, combinational:
  - Condition: E_VALID_O & E_DSTR_CS_O & E_DSTR_CS_M_O & D_VALID_I & ((D_SRC_A_CS_I & D_SRC_A_I==E_DST_O) | (D_SRC_B_CS_I & D_SRC_B_I==E_DST_O)).
  - STALL_O = hazard & ~FLUSH_I.
- Register update per rising edge, priority order:
  1. RST_I: all outputs to 0. E_VALID_O=0, E_ICODE_O=0, E_VAL_A_O=E_VAL_B_O=0, E_DST_O=0, all CS outputs=0, BUBBLE_CNT_O=0.
  2. HOLD_I: every register, including BUBBLE_CNT_O, holds its value.
  3. FLUSH_I: load bubble. E_VALID_O=0 and all CS outputs=0; data fields don't-care (implementation loads 0). Counter unchanged.
  4. Hazard: load bubble as in 3; BUBBLE_CNT_O increments, saturating at 255.
  5. Otherwise: load all D_* fields. E_VALID_O=D_VALID_I. If D_VALID_I=0, all CS outputs load 0.
- Invariant: the CS outputs are 0 whenever E_VALID_O=0, so downstream forwarding never matches a bubble.
- Write-source selects are passed through unmodified. One-hot-ness is the decoder's responsibility and is not checked here.
- Register index 0 is not special: a hazard on R0 stalls like any other register.

## Timing
- Latency: D inputs sampled at edge N appear on E outputs after edge N. One cycle, no combinational path from D data to E outputs.
- STALL_O is combinational from the E registers and D source fields, valid in the same cycle.
- Load-use sequence:
  - Cycle k: STALL_O=1.
  - Edge k: bubble enters E, counter +1.
  - Cycle k+1: the E output holds the bubble, so STALL_O=0; upstream re-presents the same instruction, which is now loaded at edge k+1.
  - The memory value is supplied by W-stage forwarding.
  - A stall never lasts more than one cycle per hazard.
- HOLD_I with a hazard present: STALL_O stays 1 for the whole hold; no bubble is inserted and no count is taken until HOLD_I deasserts.
- FLUSH_I with a hazard: flush wins, STALL_O=0, counter unchanged.
- RST_I with HOLD_I: reset wins.
- Reset mid-stall: outputs clear at that edge. STALL_O=0 in the following cycle because E_VALID_O=0.
- Counter at 255: a further hazard still inserts a bubble; the count stays 255.

## Test plan
- Reset: load valid instruction (A=0x5A, B=0xC3, DST=3, CS_E=1), then assert RST_I for 1 cycle -> next cycle all outputs 0, STALL_O=0, BUBBLE_CNT_O=0.
- Pass-through: D_VALID_I=1, ICODE=0x7, A=0x12, B=0x34, DST=5, CS=1, CS_E=1 -> one cycle later E outputs equal those values, E_VALID_O=1, STALL_O=0.
- Load-use: E holds load (DST=2, CS=1, CS_M=1); D presents SRC_A=2, SRC_A_CS=1 -> STALL_O=1; next cycle E_VALID_O=0, BUBBLE_CNT_O=1, STALL_O=0; following edge the D instruction is loaded.
- No false hazard: same as previous but SRC_A_CS=0, or E write select CS_E instead of CS_M -> STALL_O=0, no bubble.
- Hold and flush: hazard present with HOLD_I=1 for 3 cycles -> STALL_O=1 throughout, E outputs and counter unchanged. Then HOLD_I=0 with FLUSH_I=1 -> STALL_O=0, bubble loaded, counter unchanged.
- Saturation: force 256 consecutive load-use hazards -> BUBBLE_CNT_O reaches 255 and stays 255; bubbles still inserted each time.
